// File: rtl/display_input_scanner.sv
// Display-board input scanner: button shift-register scan with frame debounce, two quadrature dials.
// Defining DISPLAY_INPUT_IRQ_EN adds the interrupt control register and the irq output.
module display_input_scanner #(
   parameter int NUM_BUTTONS       = 16,
   parameter int CLK_DIV           = 25,
   parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic        shift_clkin,
   output logic        shift_load,
   input  logic        shift_out,
   input  logic [1:0]  diall,
   input  logic [1:0]  dialr,
   output logic        irq
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(NUM_BUTTONS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NUM_BUTTONS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SAMPLE, RISE, FALL, DONE} scan_state_t;

   // Gray code maps to a position around the 4-state cycle; the position delta gives the direction.
   function automatic logic signed [15:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] pos_prev;
      logic [1:0] pos_cur;
      logic [1:0] delta;
      pos_prev = {prev[1], prev[1] ^ prev[0]};
      pos_cur  = {cur[1], cur[1] ^ cur[0]};
      delta    = pos_cur - pos_prev;
      case (delta)
         2'd1:    quad_step = 16'sd1;
         2'd3:    quad_step = -16'sd1;
         default: quad_step = 16'sd0;
      endcase
   endfunction

   logic       sout_p0, sout_p1;
   logic [1:0] diall_p0, diall_p1, diall_p2;
   logic [1:0] dialr_p0, dialr_p1, dialr_p2;
   logic       vld_p0, vld_p1, vld_p2;

   // Input synchronisers; vld_p2 marks when p2 holds a real sample so reset cannot fake a step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= 1'b1;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      sout_p0  <= shift_out;
      sout_p1  <= sout_p0;
      diall_p0 <= diall;
      diall_p1 <= diall_p0;
      diall_p2 <= diall_p1;
      dialr_p0 <= dialr;
      dialr_p1 <= dialr_p0;
      dialr_p2 <= dialr_p1;
   end

   scan_state_t            state, state_next;
   logic [DIV_W-1:0]       div_cnt;
   logic [CNT_W-1:0]       bit_cnt;
   logic [NUM_BUTTONS-1:0] frame, frame_prev, buttons, sample_vec;
   logic                   tick, sample_bit, load_next, clkin_next, btn_accept;

   assign tick       = (div_cnt == DIV_LAST);
   assign sample_bit = BUTTON_ACTIVE_LOW ? ~sout_p1 : sout_p1;
   assign btn_accept = tick && (state == DONE) && (frame == frame_prev);

   always_comb begin
      sample_vec    = '0;
      sample_vec[0] = sample_bit;
   end

   always_comb begin
      state_next = state;
      if (tick) begin
         case (state)
            IDLE:    state_next = LOAD;
            LOAD:    state_next = SAMPLE;
            SAMPLE:  state_next = (NUM_BUTTONS == 1) ? DONE : RISE;
            RISE:    state_next = FALL;
            FALL:    state_next = (bit_cnt == BIT_LAST) ? DONE : RISE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
      load_next  = (state_next != LOAD);
      clkin_next = (state_next == RISE);
   end

   // Scan control; shift pins are registered so they never glitch on state decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         shift_load  <= 1'b1;
         shift_clkin <= 1'b0;
      end else begin
         state       <= state_next;
         div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
         shift_load  <= load_next;
         shift_clkin <= clkin_next;
         if (tick && state == SAMPLE)
            bit_cnt <= CNT_W'(1);
         else if (tick && state == FALL)
            bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   // Frame capture (first bit lands in the MSB) and two-frame debounce
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame      <= '0;
         frame_prev <= '0;
         buttons    <= '0;
      end else if (tick) begin
         if (state == SAMPLE || state == FALL)
            frame <= (frame << 1) | sample_vec;
         if (state == DONE) begin
            frame_prev <= frame;
            if (frame == frame_prev)
               buttons <= frame;
         end
      end
   end

   logic signed [15:0] cnt_l, cnt_r, cnt_l_next, cnt_r_next, step_l, step_r;
   logic               clr_l, clr_r;

   // A clear in the same cycle as a step leaves just the step
   always_comb begin
      step_l     = vld_p2 ? quad_step(diall_p2, diall_p1) : 16'sd0;
      step_r     = vld_p2 ? quad_step(dialr_p2, dialr_p1) : 16'sd0;
      clr_l      = write && (address == 2'd1);
      clr_r      = write && (address == 2'd2);
      cnt_l_next = clr_l ? step_l : cnt_l + step_l;
      cnt_r_next = clr_r ? step_r : cnt_r + step_r;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_l <= 16'sd0;
         cnt_r <= 16'sd0;
      end else begin
         cnt_l <= cnt_l_next;
         cnt_r <= cnt_r_next;
      end
   end

   logic [31:0] btn_word, irq_word;

   always_comb begin
      btn_word                  = '0;
      btn_word[NUM_BUTTONS-1:0] = buttons;
   end

`ifdef DISPLAY_INPUT_IRQ_EN
   logic en_btn, en_dial, pending, wr_ctrl, set_pending, unused_bits;

   assign wr_ctrl     = write && (address == 2'd3);
   assign set_pending = (en_btn && btn_accept && (frame != buttons)) ||
                        (en_dial && ((cnt_l_next != cnt_l) || (cnt_r_next != cnt_r)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_btn  <= 1'b0;
         en_dial <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en_btn  <= writedata[0];
            en_dial <= writedata[1];
         end
         if (set_pending)
            pending <= 1'b1;
         else if (wr_ctrl && writedata[2])
            pending <= 1'b0;
      end
   end

   assign irq         = pending;
   assign irq_word    = {29'b0, pending, en_dial, en_btn};
   assign unused_bits = ^writedata[31:3];
`else
   logic unused_bits;

   assign irq         = 1'b0;
   assign irq_word    = '0;
   assign unused_bits = ^{writedata, btn_accept};
`endif

   // Read port, fixed latency of one cycle; returns pre-step counter values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else if (read) begin
         case (address)
            2'd0: readdata <= btn_word;
            2'd1: readdata <= {{16{cnt_l[15]}}, cnt_l};
            2'd2: readdata <= {{16{cnt_r[15]}}, cnt_r};
            2'd3: readdata <= irq_word;
         endcase
      end
   end

endmodule

// File: tb/tb_display_input_scanner.sv
// Bench for display_input_scanner: shift-register board model, frame/dial reference model, random stimulus.
// Build with DISPLAY_INPUT_IRQ_EN defined to exercise the interrupt register.
module tb_display_input_scanner;

   localparam int NB  = 16;
   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic        write;
   logic [31:0] writedata;
   logic        shift_clkin, shift_load, shift_out;
   logic [1:0]  diall, dialr;
   logic        irq;

   display_input_scanner #(
      .NUM_BUTTONS(NB),
      .CLK_DIV(DIV),
      .BUTTON_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .read(read),
      .readdata(readdata),
      .write(write),
      .writedata(writedata),
      .shift_clkin(shift_clkin),
      .shift_load(shift_load),
      .shift_out(shift_out),
      .diall(diall),
      .dialr(dialr),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Parallel-in/serial-out board register: loads while shift_load is low, shifts on shift_clkin rise
   logic [NB-1:0] pattern;
   logic [NB-1:0] sr;
   logic          sclk_d;

   always @(posedge clk) begin
      if (!shift_load)
         sr <= pattern;
      else if (shift_clkin && !sclk_d)
         sr <= sr << 1;
      sclk_d <= shift_clkin;
   end
   assign shift_out = sr[NB-1];

   // Reference: buttons take a frame's value once two consecutive frames agree
   int            load_starts = 0;
   int            load_ends   = 0;
   logic          sl_prev = 1'b1;
   logic [NB-1:0] m_prev, m_cur, m_exp;

   always @(negedge clk) begin
      if (reset) begin
         m_prev  <= '0;
         m_cur   <= '0;
         m_exp   <= '0;
         sl_prev <= 1'b1;
      end else begin
         if (sl_prev && !shift_load) begin
            if (m_cur == m_prev)
               m_exp <= m_cur;
            m_prev      <= m_cur;
            load_starts <= load_starts + 1;
         end
         if (!sl_prev && shift_load) begin
            m_cur     <= ~sr;
            load_ends <= load_ends + 1;
         end
         sl_prev <= shift_load;
      end
   end

   logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   shortint    m_l = 0;
   shortint    m_r = 0;

   function automatic int gpos(input logic [1:0] g);
      int p = 0;
      for (int i = 0; i < 4; i++)
         if (gseq[i] == g) p = i;
      return p;
   endfunction

   function automatic shortint qstep(input logic [1:0] prev, input logic [1:0] cur);
      int d = (gpos(cur) - gpos(prev) + 4) % 4;
      if (d == 1) return 16'sd1;
      if (d == 3) return -16'sd1;
      return 16'sd0;
   endfunction

   function automatic logic [1:0] fwd(input logic [1:0] g);
      return gseq[(gpos(g) + 1) % 4];
   endfunction

   function automatic logic [31:0] sx(input shortint v);
      return 32'(int'(v));
   endfunction

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      read    = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      d    = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      @(negedge clk);
      address   = a;
      writedata = v;
      write     = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic wait_load_start();
      int start = load_starts;
      int t = 0;
      while (load_starts == start && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (load_starts == start) chk("load_start_timeout", 32'(load_starts), 32'(start + 1));
      @(negedge clk);
   endtask

   task automatic wait_load_end();
      int start = load_ends;
      int t = 0;
      while (load_ends == start && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (load_ends == start) chk("load_end_timeout", 32'(load_ends), 32'(start + 1));
      @(negedge clk);
   endtask

   task automatic set_next(input logic [NB-1:0] p);
      wait_load_end();
      pattern = p;
   endtask

   task automatic check_btn(input string tag, output logic [31:0] d);
      wait_load_start();
      rd(2'd0, d);
      chk(tag, d, 32'(m_exp));
   endtask

   task automatic move_l(input logic [1:0] v);
      @(negedge clk);
      m_l   = m_l + qstep(diall, v);
      diall = v;
      repeat (4) @(negedge clk);
   endtask

   task automatic move_r(input logic [1:0] v);
      @(negedge clk);
      m_r   = m_r + qstep(dialr, v);
      dialr = v;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]   d;
      logic [NB-1:0] p;
      int            t;
      address   = 2'd0;
      read      = 1'b0;
      write     = 1'b0;
      writedata = '0;
      diall     = 2'b00;
      dialr     = 2'b00;
      pattern   = '1;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_shift_load", 32'(shift_load), 32'd1);
      chk("rst_shift_clkin", 32'(shift_clkin), 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         chk("rst_reg", d, 32'd0);
      end

      // Buttons: steady press, single glitched frame, random frames
      check_btn("btn_idle", d);
      set_next(16'hFFFE);
      wait_load_end();
      wait_load_end();
      check_btn("btn_press_model", d);
      chk("btn_press", d, 32'h0000_0001);

      set_next(16'hFFFF);
      wait_load_end();
      wait_load_end();
      set_next(16'h7FFF);
      wait_load_end();
      pattern = 16'hFFFF;
      check_btn("btn_glitch_model", d);
      chk("btn_glitch", d, 32'h0);
      check_btn("btn_glitch_after", d);
      chk("btn_glitch_after_c", d, 32'h0);

      for (int i = 0; i < 12; i++) begin
         p = ($urandom_range(0, 1) == 1) ? pattern : NB'($urandom);
         set_next(p);
         check_btn("btn_rand", d);
      end

`ifdef DISPLAY_INPUT_IRQ_EN
      set_next(16'hFFFF);
      wait_load_end();
      wait_load_end();
      check_btn("irq_pre_btn", d);
      wr(2'd3, 32'h5);
      rd(2'd3, d);
      chk("irq_ctrl_en", d, 32'h1);
      chk("irq_idle", 32'(irq), 32'd0);
      set_next(16'hFFFD);
      wait_load_end();
      wait_load_end();
      check_btn("irq_btn", d);
      chk("irq_set", 32'(irq), 32'd1);
      rd(2'd3, d);
      chk("irq_ctrl_pend", d, 32'h5);
      wr(2'd3, 32'h5);
      chk("irq_clear", 32'(irq), 32'd0);
`else
      wr(2'd3, 32'h7);
      rd(2'd3, d);
      chk("reg3_ignored", d, 32'h0);
      set_next(16'hFFFD);
      wait_load_end();
      wait_load_end();
      check_btn("noirq_btn", d);
      chk("irq_tied", 32'(irq), 32'd0);
`endif

      // Dial L: four forward, one reverse, then illegal double-bit jumps
      wr(2'd1, 32'h0);
      m_l = 0;
      move_l(2'b01); move_l(2'b11); move_l(2'b10); move_l(2'b00);
      move_l(2'b10);
      rd(2'd1, d);
      chk("diall_fwd_rev", d, 32'h0000_0003);
      chk("diall_fwd_rev_model", d, sx(m_l));
      move_l(2'b01);
      rd(2'd1, d);
      chk("diall_illegal_a", d, 32'h0000_0003);
      move_l(2'b00);
      move_l(2'b11);
      rd(2'd1, d);
      chk("diall_illegal_b", d, 32'h0000_0002);

      // Dial R: five reverse steps
      wr(2'd2, 32'h0);
      m_r = 0;
      move_r(2'b10); move_r(2'b11); move_r(2'b01); move_r(2'b00); move_r(2'b10);
      rd(2'd2, d);
      chk("dialr_rev5", d, 32'hFFFF_FFFB);

      // Write-clear landing on the same cycle as a forward step
      @(negedge clk);
      dialr = 2'b00;
      @(negedge clk);
      @(negedge clk);
      address = 2'd2; writedata = 32'h0; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      m_r = 1;
      repeat (3) @(negedge clk);
      rd(2'd2, d);
      chk("dialr_clr_step_fwd", d, 32'h0000_0001);

      // Same, reverse step
      @(negedge clk);
      dialr = 2'b10;
      @(negedge clk);
      @(negedge clk);
      address = 2'd2; writedata = 32'h1234; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      m_r = -1;
      repeat (3) @(negedge clk);
      rd(2'd2, d);
      chk("dialr_clr_step_rev", d, 32'hFFFF_FFFF);

      // Read on the same cycle as a step returns the pre-step value
      @(negedge clk);
      dialr = 2'b00;
      @(negedge clk);
      @(negedge clk);
      address = 2'd2; read = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0;
      d = readdata;
      m_r = 0;
      chk("dialr_read_prestep", d, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      rd(2'd2, d);
      chk("dialr_after_step", d, sx(m_r));

      // Random dial motion, including illegal jumps
      for (int i = 0; i < 30; i++) begin
         move_l(2'($urandom_range(0, 3)));
         move_r(2'($urandom_range(0, 3)));
         if (i % 10 == 9) begin
            rd(2'd1, d);
            chk("diall_rand", d, sx(m_l));
            rd(2'd2, d);
            chk("dialr_rand", d, sx(m_r));
         end
      end

      // Wrap from +32767 to -32768
      wr(2'd1, 32'h0);
      m_l = 0;
      for (int i = 0; i < 32767; i++) begin
         @(negedge clk);
         m_l   = m_l + qstep(diall, fwd(diall));
         diall = fwd(diall);
      end
      repeat (5) @(negedge clk);
      rd(2'd1, d);
      chk("diall_max", d, 32'h0000_7FFF);
      move_l(fwd(diall));
      rd(2'd1, d);
      chk("diall_wrap", d, 32'hFFFF_8000);
      chk("diall_wrap_model", d, sx(m_l));

      // Asynchronous reset in the middle of a shift-clock high phase
      t = 0;
      while (shift_clkin !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("clkin_seen", 32'(shift_clkin), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_shift_load", 32'(shift_load), 32'd1);
      chk("arst_shift_clkin", 32'(shift_clkin), 32'd0);
      chk("arst_readdata", readdata, 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      m_l = 0;
      m_r = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      rd(2'd0, d);
      chk("arst_buttons", d, 32'h0);
      rd(2'd1, d);
      chk("arst_diall", d, sx(m_l));
      rd(2'd2, d);
      chk("arst_dialr", d, sx(m_r));
      wait_load_end();
      wait_load_end();
      check_btn("post_rst_btn", d);
      chk("post_rst_btn_c", d, 32'h0000_0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
